// File: rtl/pointwise_ub_sched.sv
// pointwise_ub_sched
//
// Schedule controller for the pointwise pipeline. It runs three loop nests
// (input-wrapper write, mult compute, hw_output read), each WIDTH x HEIGHT at
// II=1. Each nest is offset from the first input write by a fixed start delay,
// so every read lands after the write to the same address.
//
// Ports
//   clk             clock
//   rst_n           asynchronous active-low reset
//   flush           synchronous abort back to idle (beats start and stall)
//   start           launch request, sampled only while idle
//   stall           freezes every stage for the cycle it selects
//   busy            a run is in progress
//   done            one-cycle pulse in the cycle after the final out_ren
//   in_wen          input-wrapper stencil write enable
//   in_ctrl_vars    input counters: [0]=root (always 0), [1]=x, [2]=y
//   mult_en         mult_stencil read enable / mult write enable
//   mult_ctrl_vars  mult counters, same layout
//   out_ren         hw_output stencil read enable
//   out_ctrl_vars   output counters, same layout
//
// All outputs come straight from flops. Inputs sampled at edge e decide what
// the outputs show in the cycle that edge opens.

module pointwise_ub_sched #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned DELAY_MULT = 1,
  parameter int unsigned DELAY_OUT  = 2,
  parameter int unsigned CW         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 in_wen,
  output logic [2:0][CW-1:0]   in_ctrl_vars,
  output logic                 mult_en,
  output logic [2:0][CW-1:0]   mult_ctrl_vars,
  output logic                 out_ren,
  output logic [2:0][CW-1:0]   out_ctrl_vars
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DELAY_MULT < 1) begin : g_bad_delay_mult
    $error("pointwise_ub_sched: DELAY_MULT must be at least 1");
  end
  if (DELAY_OUT <= DELAY_MULT) begin : g_bad_delay_out
    $error("pointwise_ub_sched: DELAY_OUT must exceed DELAY_MULT");
  end
  if ((64'(WIDTH) > (64'd1 << CW)) || (64'(HEIGHT) > (64'd1 << CW))) begin : g_bad_cw
    $error("pointwise_ub_sched: WIDTH and HEIGHT must fit in CW bits");
  end
  if ((WIDTH < 1) || (HEIGHT < 1)) begin : g_bad_extent
    $error("pointwise_ub_sched: WIDTH and HEIGHT must be non-zero");
  end

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int unsigned NumIter = WIDTH * HEIGHT;
  // The global counter must reach DELAY_OUT + NumIter, the value that marks
  // every stage as finished.
  localparam int unsigned RunLen  = DELAY_OUT + NumIter;
  localparam int unsigned TW      = $clog2(RunLen + 1);

  typedef logic [TW-1:0] tcnt_t;
  typedef logic [CW-1:0] var_t;

  localparam tcnt_t RunEnd = TW'(RunLen);
  localparam tcnt_t Iter   = TW'(NumIter);
  localparam var_t  XLast  = CW'(WIDTH - 1);

  // Stage index: 0 = input write, 1 = mult, 2 = output read.
  localparam logic [2:0][TW-1:0] StageOff = {TW'(DELAY_OUT), TW'(DELAY_MULT), TW'(0)};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q;
  // Global step for the next unstalled run cycle. It is 0 while idle, so the
  // start edge loads step 0 and the counter then sits at 1.
  tcnt_t           t_q;
  logic            busy_q;
  logic            done_q;
  logic [2:0]      en_q;
  logic [2:0][CW-1:0] x_q;
  logic [2:0][CW-1:0] y_q;

  // ---------------------------------------------------------------------------
  // Per-stage next iteration for the step about to be issued
  // ---------------------------------------------------------------------------
  tcnt_t           t_cur;
  logic [2:0]      act_d;
  logic [2:0][CW-1:0] x_d;
  logic [2:0][CW-1:0] y_d;

  always_comb begin
    t_cur = (state_q == StIdle) ? '0 : t_q;
    act_d = '0;
    x_d   = '0;
    y_d   = '0;
    for (int s = 0; s < 3; s++) begin
      act_d[s] = (t_cur >= StageOff[s]) && ((t_cur - StageOff[s]) < Iter);
      // The first active step of a stage is (0,0). After that, advance from
      // the held counters. Stalls leave those counters untouched, so raster
      // order survives any stall pattern.
      if (act_d[s] && (t_cur != StageOff[s])) begin
        if (x_q[s] == XLast) begin
          x_d[s] = '0;
          y_d[s] = y_q[s] + var_t'(1);
        end else begin
          x_d[s] = x_q[s] + var_t'(1);
          y_d[s] = y_q[s];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (flush) begin
      // Abort: return to idle without a completion pulse.
      state_q <= StIdle;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            t_q     <= TW'(1);
            en_q    <= act_d;
            x_q     <= x_d;
            y_q     <= y_d;
          end else begin
            t_q  <= '0;
            en_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
          end
        end

        StRun: begin
          if (t_q == RunEnd) begin
            // The previous cycle held the final out_ren. This cycle is the
            // completion cycle, and it is already idle, so start is accepted.
            state_q <= StIdle;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            en_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
          end else if (stall) begin
            // Freeze: no strobes, and the counters and ctrl_vars hold.
            en_q <= '0;
          end else begin
            t_q  <= t_q + TW'(1);
            en_q <= act_d;
            x_q  <= x_d;
            y_q  <= y_d;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy           = busy_q;
  assign done           = done_q;
  assign in_wen         = en_q[0];
  assign mult_en        = en_q[1];
  assign out_ren        = en_q[2];
  assign in_ctrl_vars   = {y_q[0], x_q[0], var_t'(0)};
  assign mult_ctrl_vars = {y_q[1], x_q[1], var_t'(0)};
  assign out_ctrl_vars  = {y_q[2], x_q[2], var_t'(0)};

  // ---------------------------------------------------------------------------
  // Sanity properties
  // ---------------------------------------------------------------------------
  // No strobe may fire outside a run.
  a_en_in_run : assert property (@(posedge clk) disable iff (!rst_n)
    (in_wen || mult_en || out_ren) |-> busy);

  // The completion pulse lands in an idle cycle.
  a_done_idle : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

  // The completion pulse is a single cycle wide.
  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_pointwise_ub_sched.sv
module tb_pointwise_ub_sched;

  localparam int DM = 1;
  localparam int DO = 2;

  logic clk;
  logic rst_n;
  logic flush;
  logic start;
  logic stall;

  logic            busy_w [2];
  logic            done_w [2];
  logic            en_w   [2][3];
  logic [2:0][15:0] cv_w  [2][3];

  // Instance 0: 4x2 config. Instance 1: defaults (64x64). Both share stimulus.
  pointwise_ub_sched #(
    .WIDTH(4), .HEIGHT(2), .DELAY_MULT(DM), .DELAY_OUT(DO), .CW(16)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .stall(stall),
    .busy(busy_w[0]), .done(done_w[0]),
    .in_wen(en_w[0][0]), .in_ctrl_vars(cv_w[0][0]),
    .mult_en(en_w[0][1]), .mult_ctrl_vars(cv_w[0][1]),
    .out_ren(en_w[0][2]), .out_ctrl_vars(cv_w[0][2])
  );

  pointwise_ub_sched u_big (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .stall(stall),
    .busy(busy_w[1]), .done(done_w[1]),
    .in_wen(en_w[1][0]), .in_ctrl_vars(cv_w[1][0]),
    .mult_en(en_w[1][1]), .mult_ctrl_vars(cv_w[1][1]),
    .out_ren(en_w[1][2]), .out_ctrl_vars(cv_w[1][2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The schedule is a function of the unstalled step index
  // t: stage s shows (x,y) = ((t-D_s) mod W, (t-D_s) div W) when
  // D_s <= t < D_s + W*H.
  // ---------------------------------------------------------------------------
  bit m_run  [2];
  bit m_busy [2];
  bit m_done [2];
  int m_t    [2];
  bit m_en   [2][3];
  int m_x    [2][3];
  int m_y    [2][3];

  function automatic int cfg_w(int k);
    return (k == 0) ? 4 : 64;
  endfunction

  function automatic int cfg_h(int k);
    return (k == 0) ? 2 : 64;
  endfunction

  function automatic int stage_off(int s);
    return (s == 0) ? 0 : ((s == 1) ? DM : DO);
  endfunction

  function automatic void m_clear(int k);
    for (int s = 0; s < 3; s++) begin
      m_en[k][s] = 1'b0;
      m_x[k][s]  = 0;
      m_y[k][s]  = 0;
    end
  endfunction

  function automatic void m_show(int k, int t);
    int n;
    int off;
    n = cfg_w(k) * cfg_h(k);
    for (int s = 0; s < 3; s++) begin
      off = stage_off(s);
      if (t >= off && t < off + n) begin
        m_en[k][s] = 1'b1;
        m_x[k][s]  = (t - off) % cfg_w(k);
        m_y[k][s]  = (t - off) / cfg_w(k);
      end else begin
        m_en[k][s] = 1'b0;
        m_x[k][s]  = 0;
        m_y[k][s]  = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_t[k] = 0;
      m_clear(k);
    end
  endfunction

  // Called right after each rising edge with the inputs that edge sampled.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || flush) begin
        m_run[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_t[k] = 0;
        m_clear(k);
      end else if (!m_run[k]) begin
        m_done[k] = 1'b0;
        if (start) begin
          m_run[k] = 1'b1; m_busy[k] = 1'b1;
          m_show(k, 0);
          m_t[k] = 1;
        end else begin
          m_clear(k);
        end
      end else if (m_t[k] == DO + cfg_w(k) * cfg_h(k)) begin
        m_run[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b1;
        m_clear(k);
      end else if (stall) begin
        for (int s = 0; s < 3; s++) m_en[k][s] = 1'b0;
      end else begin
        m_show(k, m_t[k]);
        m_t[k]++;
      end
    end
  endfunction

  // The compare process runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model busy[%0d]", k), longint'(busy_w[k]), longint'(m_busy[k]));
        chk($sformatf("model done[%0d]", k), longint'(done_w[k]), longint'(m_done[k]));
        for (int s = 0; s < 3; s++) begin
          chk($sformatf("model en[%0d][%0d]", k, s), longint'(en_w[k][s]),
              longint'(m_en[k][s]));
          chk($sformatf("model vars[%0d][%0d]", k, s), longint'(cv_w[k][s]),
              longint'({16'(m_y[k][s]), 16'(m_x[k][s]), 16'd0}));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int en_cnt   [2][3];
  int done_cnt [2];

  task automatic clr_cnt();
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      for (int s = 0; s < 3; s++) en_cnt[k][s] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (done_w[k]) done_cnt[k]++;
      for (int s = 0; s < 3; s++) if (en_w[k][s]) en_cnt[k][s]++;
    end
  endtask

  task automatic chk_small_counts(input string tag, input int n_en, input int n_done);
    for (int s = 0; s < 3; s++)
      chk($sformatf("%s en_count[%0d]", tag, s), longint'(en_cnt[0][s]), longint'(n_en));
    chk($sformatf("%s done_count", tag), longint'(done_cnt[0]), longint'(n_done));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  int rcyc;
  logic             prev_men;
  logic [2:0][15:0] prev_mv;
  logic [2:0][15:0] last_in;

  initial begin
    flush = 1'b0; start = 1'b0; stall = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset busy", longint'(busy_w[0]), 0);
    chk("reset in_wen", longint'(en_w[0][0]), 0);
    chk("reset out_vars", longint'(cv_w[0][2]), 0);

    // Test 1: a single run, start sampled at edge 0.
    clr_cnt();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      chk("t1 in_wen", longint'(en_w[0][0]), longint'(r <= 8));
      chk("t1 mult_en", longint'(en_w[0][1]), longint'(r >= 2 && r <= 9));
      chk("t1 out_ren", longint'(en_w[0][2]), longint'(r >= 3 && r <= 10));
      chk("t1 busy", longint'(busy_w[0]), longint'(r <= 10));
      chk("t1 done", longint'(done_w[0]), longint'(r == 11));
      if (r == 1) chk("t1 first in vars", longint'(cv_w[0][0]), 48'h0000_0000_0000);
      if (r == 6) chk("t1 in vars c6", longint'(cv_w[0][0]), 48'h0001_0001_0000);
      if (r == 8) chk("t1 last in vars", longint'(cv_w[0][0]), 48'h0001_0003_0000);
      if (r == 10) chk("t1 last out vars", longint'(cv_w[0][2]), 48'h0001_0003_0000);
      if (r < 12) tick();
    end
    chk_small_counts("t1", 8, 1);

    // Test 2: stall covers cycles 4 and 5.
    clr_cnt();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 13; r++) begin
      if (r == 4 || r == 5) begin
        for (int s = 0; s < 3; s++)
          chk($sformatf("t2 stalled en[%0d]", s), longint'(en_w[0][s]), 0);
        chk("t2 held in vars", longint'(cv_w[0][0]), 48'h0000_0002_0000);
        chk("t2 held mult vars", longint'(cv_w[0][1]), 48'h0000_0001_0000);
      end
      if (r == 6) chk("t2 resumed in vars", longint'(cv_w[0][0]), 48'h0000_0003_0000);
      chk("t2 done", longint'(done_w[0]), longint'(r == 13));
      chk("t2 busy", longint'(busy_w[0]), longint'(r <= 12));
      stall = (r == 3 || r == 4);
      if (r < 13) tick();
    end
    stall = 1'b0;
    chk_small_counts("t2", 8, 1);

    // Tests 3 and 4: start pulses while busy are ignored; start in the done
    // cycle launches a second run.
    clr_cnt();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 23; r++) begin
      chk("t3 in_wen", longint'(en_w[0][0]),
          longint'((r >= 1 && r <= 8) || (r >= 12 && r <= 19)));
      chk("t3 done", longint'(done_w[0]), longint'(r == 11 || r == 22));
      if (r == 12) chk("t4 second run first vars", longint'(cv_w[0][0]), 0);
      start = (r == 3 || r == 7 || r == 11);
      if (r < 23) tick();
    end
    start = 1'b0;
    chk_small_counts("t3", 16, 2);

    // Test 5: flush sampled at the end of cycle 5.
    clr_cnt();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 7; r++) begin
      if (r == 6) begin
        chk("t5 flushed busy", longint'(busy_w[0]), 0);
        for (int s = 0; s < 3; s++) begin
          chk($sformatf("t5 flushed en[%0d]", s), longint'(en_w[0][s]), 0);
          chk($sformatf("t5 flushed vars[%0d]", s), longint'(cv_w[0][s]), 0);
        end
      end
      flush = (r == 5);
      tick();
    end
    flush = 1'b0;
    chk("t5 in_wen before flush", longint'(en_cnt[0][0]), 5);
    chk("t5 no done", longint'(done_cnt[0]), 0);
    clr_cnt();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk_small_counts("t5 clean run", 8, 1);

    // Test 6: default config, asynchronous reset mid-run, then a full run.
    repeat (50) tick();
    chk("t6 big busy before reset", longint'(busy_w[1]), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6 async reset busy", longint'(busy_w[1]), 0);
    chk("t6 async reset in_wen", longint'(en_w[1][0]), 0);
    chk("t6 async reset in vars", longint'(cv_w[1][0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_cnt();
    start = 1'b1;
    tick();
    start = 1'b0;
    rcyc = 1;
    last_in = cv_w[1][0];
    while (!done_w[1] && rcyc < 6000) begin
      prev_men = en_w[1][1];
      prev_mv  = cv_w[1][1];
      tick();
      rcyc++;
      chk("t6 out follows mult", longint'(en_w[1][2]), longint'(prev_men));
      if (en_w[1][2]) chk("t6 out addr", longint'(cv_w[1][2]), longint'(prev_mv));
      if (en_w[1][0]) last_in = cv_w[1][0];
    end
    chk("t6 done seen", longint'(done_w[1]), 1);
    chk("t6 run length", longint'(rcyc), 4099);
    for (int s = 0; s < 3; s++)
      chk($sformatf("t6 en_count[%0d]", s), longint'(en_cnt[1][s]), 4096);
    chk("t6 last in vars", longint'(last_in), 48'h003f_003f_0000);
    chk("t6 done count", longint'(done_cnt[1]), 1);
    tick();

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
